// File: rtl/bayer_pkg.sv
// Shared widths, row-parity type and quad arithmetic helpers for the Bayer-to-gray decimator.
package bayer_pkg;

  localparam int PIX_W     = 12;
  localparam int PAIR_W    = 13;
  localparam int SUM_W     = 14;
  localparam int IN_W_DEF  = 1280;
  localparam int CNT_W_DEF = 11;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_t;

  // Horizontal pair sum: two 12-bit pixels never overflow 13 bits.
  function automatic logic [PAIR_W-1:0] pairSum(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    return PAIR_W'(a) + PAIR_W'(b);
  endfunction

  function automatic logic [SUM_W-1:0] quadSum(input logic [PAIR_W-1:0] p,
                                                input logic [PIX_W-1:0]  a,
                                                input logic [PIX_W-1:0]  b);
    return SUM_W'(p) + SUM_W'(a) + SUM_W'(b);
  endfunction

endpackage

// File: rtl/bayer_line_buf.sv
// Simple dual-port line buffer holding the even-row pair sums; registered read, no storage reset.
module bayer_line_buf
  import bayer_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [PAIR_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [PAIR_W-1:0] o_rdata
);

  logic [PAIR_W-1:0] r_mem [DEPTH];
  logic [PAIR_W-1:0] r_rdData;

  // Kept free of reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdData <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdData;

endmodule

// File: rtl/bayer_to_gray.sv
// 2x2 Bayer quad to 12-bit gray decimator: even rows buffer pair sums, odd rows combine and emit.
module bayer_to_gray
  import bayer_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = IN_W / 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iDATA,
  output logic             oDVAL,
  output logic [PIX_W-1:0] oGRAY,
  output logic             oLINE_ERR
);

  localparam int AW = $clog2(OUT_W);

  row_t              r_parity;
  logic [CNT_W-1:0]  r_col;
  logic [PIX_W-1:0]  r_pair;
  logic              r_inLine;
  logic              r_errSeen;
  logic              r_dval;
  logic [PIX_W-1:0]  r_gray;
  logic              r_lineErr;

  logic              w_colFull;
  logic              w_accept;
  logic              w_overflow;
  logic              w_lineEnd;
  logic              w_oddCol;
  logic              w_we;
  logic              w_re;
  logic [AW-1:0]     w_addr;
  logic [PAIR_W-1:0] w_wrData;
  logic [PAIR_W-1:0] w_rdData;
  logic [SUM_W-1:0]  w_sum;

  assign w_colFull  = (r_col >= CNT_W'(IN_W));
  assign w_accept   = iFVAL && iDVAL && !w_colFull;
  assign w_overflow = iFVAL && iDVAL && w_colFull;
  assign w_lineEnd  = iFVAL && !iDVAL && r_inLine;
  assign w_oddCol   = r_col[0];
  assign w_addr     = AW'(r_col >> 1);

  assign w_we     = w_accept && (r_parity == ROW_EVEN) && w_oddCol;
  assign w_re     = w_accept && (r_parity == ROW_ODD) && !w_oddCol;
  assign w_wrData = pairSum(r_pair, iDATA);
  assign w_sum    = quadSum(w_rdData, r_pair, iDATA);

  bayer_line_buf #(
    .DEPTH (OUT_W),
    .AW    (AW)
  ) u_lineBuf (
    .i_clk   (iCLK),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_wrData),
    .i_re    (w_re),
    .i_raddr (w_addr),
    .o_rdata (w_rdData)
  );

  // Frame gap has priority over line end; pixels past IN_W only raise the one-shot error.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_parity  <= ROW_EVEN;
      r_col     <= '0;
      r_pair    <= '0;
      r_inLine  <= 1'b0;
      r_errSeen <= 1'b0;
      r_dval    <= 1'b0;
      r_gray    <= '0;
      r_lineErr <= 1'b0;
    end else begin
      r_dval    <= 1'b0;
      r_lineErr <= 1'b0;
      if (!iFVAL) begin
        r_parity  <= ROW_EVEN;
        r_col     <= '0;
        r_inLine  <= 1'b0;
        r_errSeen <= 1'b0;
      end else if (w_lineEnd) begin
        r_parity  <= (r_parity == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        r_col     <= '0;
        r_inLine  <= 1'b0;
        r_errSeen <= 1'b0;
      end else if (w_accept) begin
        r_col    <= r_col + CNT_W'(1);
        r_inLine <= 1'b1;
        if (!w_oddCol) begin
          r_pair <= iDATA;
        end else if (r_parity == ROW_ODD) begin
          r_dval <= 1'b1;
          r_gray <= PIX_W'(w_sum >> 2);
        end
      end else if (w_overflow && !r_errSeen) begin
        r_lineErr <= 1'b1;
        r_errSeen <= 1'b1;
      end
    end
  end

  assign oDVAL     = r_dval;
  assign oGRAY     = r_gray;
  assign oLINE_ERR = r_lineErr;

endmodule
